// File: rtl/qeciphy_pkg.sv
// Shared QECIPHY definitions: RX checker state encoding, sequence mode selectors
// and the xorshift64 step used by the stream generators/checkers.
package qeciphy_pkg;

   typedef enum logic [1:0] {
      CHK_IDLE,
      CHK_SEED,
      CHK_CHECK,
      CHK_DONE
   } qeciphy_chk_state_t;

   localparam int unsigned QECIPHY_CHK_MODE_COUNTER  = 0;
   localparam int unsigned QECIPHY_CHK_MODE_XORSHIFT = 1;

   function automatic logic [63:0] qeciphy_xorshift64(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

endpackage

// File: rtl/qeciphy_rx_checker_gen.sv
// Expected-value generator for the RX checker: holds the last accepted word and
// presents next() of it for the selected sequence MODE.
module qeciphy_rx_checker_gen
   import qeciphy_pkg::*;
#(
   parameter int unsigned MODE = QECIPHY_CHK_MODE_COUNTER
) (
   input  logic        aclk,
   input  logic        arst,
   input  logic        load,
   input  logic [63:0] din,
   output logic [63:0] next_word
);

   logic [63:0] state_q;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_q <= '0;
      end else if (load) begin
         state_q <= din;
      end
   end

   always_comb begin
      if (MODE == QECIPHY_CHK_MODE_XORSHIFT) begin
         next_word = qeciphy_xorshift64(state_q);
      end else begin
         next_word = state_q + 64'd1;
      end
   end

endmodule

// File: rtl/qeciphy_rx_checker.sv
// Self-seeding checker for the QECIPHY 64-bit RX stream; reports lock, completion and
// error statistics. Define QECIPHY_RX_CHECKER_ERR_LOG_EN to capture first-mismatch words.
module qeciphy_rx_checker
   import qeciphy_pkg::*;
#(
   parameter int unsigned MODE    = QECIPHY_CHK_MODE_COUNTER,
   parameter int unsigned SEQ_LEN = 2048
) (
   input  logic        ACLK,
   input  logic        ARST,
   input  logic [63:0] RX_TDATA,
   input  logic        RX_TVALID,
   output logic        RX_TREADY,
   input  logic        START,
   input  logic        CLEAR,
   output logic        LOCKED,
   output logic        DONE,
   output logic        PASS,
   output logic        OVERRUN,
   output logic [31:0] WORD_CNT,
   output logic [15:0] ERR_CNT,
   output logic [31:0] FIRST_ERR_IDX,
   output logic [63:0] FIRST_ERR_EXP,
   output logic [63:0] FIRST_ERR_RCV
);

   localparam logic [31:0] SEQ_LEN_W = 32'(SEQ_LEN);

   qeciphy_chk_state_t state_q, state_d;
   logic        tready_q;
   logic        locked_q, locked_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        ovr_q, ovr_d;
   logic [31:0] word_q, word_d;
   logic [15:0] err_q, err_d;
   logic [31:0] fidx_q, fidx_d;
   logic        beat;
   logic        gen_load;
   logic [63:0] gen_next;
   logic        mismatch;

`ifdef QECIPHY_RX_CHECKER_ERR_LOG_EN
   logic [63:0] fexp_q, fexp_d;
   logic [63:0] frcv_q, frcv_d;
`endif

   qeciphy_rx_checker_gen #(
      .MODE(MODE)
   ) u_gen (
      .aclk      (ACLK),
      .arst      (ARST),
      .load      (gen_load),
      .din       (RX_TDATA),
      .next_word (gen_next)
   );

   assign beat     = RX_TVALID && tready_q;
   assign mismatch = (RX_TDATA != gen_next);

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      err_d    = err_q;
      fidx_d   = fidx_q;
      ovr_d    = ovr_q;
      gen_load = 1'b0;
`ifdef QECIPHY_RX_CHECKER_ERR_LOG_EN
      fexp_d   = fexp_q;
      frcv_d   = frcv_q;
`endif

      if (CLEAR || START) begin
         state_d = CLEAR ? CHK_IDLE : CHK_SEED;
         word_d  = '0;
         err_d   = '0;
         fidx_d  = '0;
         ovr_d   = 1'b0;
`ifdef QECIPHY_RX_CHECKER_ERR_LOG_EN
         fexp_d  = '0;
         frcv_d  = '0;
`endif
      end else if (beat) begin
         unique case (state_q)
            CHK_IDLE: ;
            CHK_SEED: begin
               gen_load = 1'b1;
               word_d   = 32'd1;
               state_d  = CHK_CHECK;
            end
            CHK_CHECK: begin
               // generator always reloads from the received word so a single
               // corrupted beat does not cascade into a burst of errors
               gen_load = 1'b1;
               if (mismatch) begin
                  if (err_q == '0) begin
                     fidx_d = word_q;
`ifdef QECIPHY_RX_CHECKER_ERR_LOG_EN
                     fexp_d = gen_next;
                     frcv_d = RX_TDATA;
`endif
                  end
                  if (err_q != '1) begin
                     err_d = err_q + 16'd1;
                  end
               end
               word_d = word_q + 32'd1;
               if (word_d == SEQ_LEN_W) begin
                  state_d = CHK_DONE;
               end
            end
            CHK_DONE: ovr_d = 1'b1;
            default: ;
         endcase
      end

      locked_d = (state_d == CHK_CHECK);
      done_d   = (state_d == CHK_DONE);
      pass_d   = done_d && (err_d == '0) && !ovr_d;
   end

   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         state_q  <= CHK_IDLE;
         tready_q <= 1'b0;
         locked_q <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         ovr_q    <= 1'b0;
         word_q   <= '0;
         err_q    <= '0;
         fidx_q   <= '0;
      end else begin
         state_q  <= state_d;
         tready_q <= 1'b1;
         locked_q <= locked_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         ovr_q    <= ovr_d;
         word_q   <= word_d;
         err_q    <= err_d;
         fidx_q   <= fidx_d;
      end
   end

`ifdef QECIPHY_RX_CHECKER_ERR_LOG_EN
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         fexp_q <= '0;
         frcv_q <= '0;
      end else begin
         fexp_q <= fexp_d;
         frcv_q <= frcv_d;
      end
   end

   assign FIRST_ERR_EXP = fexp_q;
   assign FIRST_ERR_RCV = frcv_q;
`else
   assign FIRST_ERR_EXP = '0;
   assign FIRST_ERR_RCV = '0;
`endif

   assign RX_TREADY     = tready_q;
   assign LOCKED        = locked_q;
   assign DONE          = done_q;
   assign PASS          = pass_q;
   assign OVERRUN       = ovr_q;
   assign WORD_CNT      = word_q;
   assign ERR_CNT       = err_q;
   assign FIRST_ERR_IDX = fidx_q;

endmodule
